// File: rtl/hazard_detection_unit.sv
// Hazard detection unit for a 5-stage RISC-V pipeline, placed in ID.
// Inserts load-use and branch-operand bubbles that EX-stage forwarding
// cannot cover. Freezes the pipeline on cache misses. Flushes IF/ID on
// taken ID-stage branches. Counts every inserted bubble.
//
// state | meaning
// IDLE  | evaluate hazards, stall for zero or one cycle
// HOLD  | second bubble of a load feeding a branch, no evaluation
module hazard_detection_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           IF_ID_rs1,
  input  logic [4:0]           IF_ID_rs2,
  input  logic                 use_rs1,
  input  logic                 use_rs2,
  input  logic                 branch_id,
  input  logic                 branch_taken,
  input  logic [4:0]           ID_EX_rd,
  input  logic                 ID_EX_memread,
  input  logic                 ID_EX_regwrite,
  input  logic [4:0]           EX_MEM_rd,
  input  logic                 EX_MEM_memread,
  input  logic                 icache_stall,
  input  logic                 dcache_stall,
  output logic                 pc_write,
  output logic                 IF_ID_write,
  output logic                 ID_EX_write,
  output logic                 ID_EX_bubble,
  output logic                 IF_ID_flush,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state;
  logic       cnt;
  logic       ex_match;
  logic       mem_match;
  logic       freeze;
  logic       stall;
  logic [1:0] need;

  // Source-register matches against the EX and MEM destinations; x0 never matches.
  always_comb begin
    ex_match  = (use_rs1 && (IF_ID_rs1 != 5'd0) && (IF_ID_rs1 == ID_EX_rd)) ||
                (use_rs2 && (IF_ID_rs2 != 5'd0) && (IF_ID_rs2 == ID_EX_rd));
    mem_match = (use_rs1 && (IF_ID_rs1 != 5'd0) && (IF_ID_rs1 == EX_MEM_rd)) ||
                (use_rs2 && (IF_ID_rs2 != 5'd0) && (IF_ID_rs2 == EX_MEM_rd));
  end

  // Number of bubbles the ID instruction needs; the largest applicable case wins.
  always_comb begin
    need = 2'd0;
    if (ID_EX_memread && ex_match && branch_id)
      need = 2'd2;
    else if ((ID_EX_memread && ex_match) ||
             (!ID_EX_memread && ID_EX_regwrite && ex_match && branch_id) ||
             (EX_MEM_memread && mem_match && branch_id))
      need = 2'd1;
  end

  // Pipeline control: reset forces run, freeze beats stall, stall beats flush.
  always_comb begin
    freeze       = icache_stall || dcache_stall;
    stall        = !rst && !freeze && ((state == HOLD) || (need != 2'd0));
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    if (!rst) begin
      if (freeze) begin
        pc_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_write = 1'b0;
      end else if (stall) begin
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
      end else begin
        IF_ID_flush = branch_taken;
      end
    end
  end

  // FSM and bubble counter; a cache freeze holds everything in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 1'b0;
      stall_cycles <= '0;
    end else if (!freeze) begin
      case (state)
        IDLE: begin
          if (need == 2'd2) begin
            state <= HOLD;
            cnt   <= 1'b0;
          end
        end
        HOLD: begin
          if (cnt == 1'b0)
            state <= IDLE;
          else
            cnt <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (stall)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: single-cycle vector table plus
// hand-written multi-cycle sequences (double bubble, freeze, reset, wrap).
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd, EX_MEM_rd;
  logic       use_rs1, use_rs2, branch_id, branch_taken;
  logic       ID_EX_memread, ID_EX_regwrite, EX_MEM_memread;
  logic       icache_stall, dcache_stall;
  logic       pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble, IF_ID_flush;
  logic [3:0] stall_cycles;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_cnt;

  // {pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble, IF_ID_flush}
  localparam logic [4:0] RUN   = 5'b11100;
  localparam logic [4:0] STALL = 5'b00110;
  localparam logic [4:0] FLUSH = 5'b11101;
  localparam logic [4:0] FRZ   = 5'b00000;

  hazard_detection_unit #(.CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .use_rs1(use_rs1), .use_rs2(use_rs2),
    .branch_id(branch_id), .branch_taken(branch_taken),
    .ID_EX_rd(ID_EX_rd), .ID_EX_memread(ID_EX_memread), .ID_EX_regwrite(ID_EX_regwrite),
    .EX_MEM_rd(EX_MEM_rd), .EX_MEM_memread(EX_MEM_memread),
    .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       u1, u2, br, bt;
    logic [4:0] exrd;
    logic       exmr, exrw;
    logic [4:0] memrd;
    logic       memmr, ic, dc;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(string name, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                              logic br, logic bt, logic [4:0] exrd, logic exmr, logic exrw,
                              logic [4:0] memrd, logic memmr, logic ic, logic dc, logic [4:0] exp);
    vec_t v;
    v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.br = br; v.bt = bt;
    v.exrd = exrd; v.exmr = exmr; v.exrw = exrw; v.memrd = memrd; v.memmr = memmr;
    v.ic = ic; v.dc = dc; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    IF_ID_rs1 = v.rs1; IF_ID_rs2 = v.rs2; use_rs1 = v.u1; use_rs2 = v.u2;
    branch_id = v.br; branch_taken = v.bt; ID_EX_rd = v.exrd;
    ID_EX_memread = v.exmr; ID_EX_regwrite = v.exrw;
    EX_MEM_rd = v.memrd; EX_MEM_memread = v.memmr;
    icache_stall = v.ic; dcache_stall = v.dc;
  endtask

  task automatic check_out(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {pc_write, IF_ID_write, ID_EX_write, ID_EX_bubble, IF_ID_flush};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: outputs got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [3:0] exp);
    checks++;
    if (stall_cycles !== exp) begin
      failures++;
      $display("FAIL %s: stall_cycles got %0d expected %0d", name, stall_cycles, exp);
    end
  endtask

  // Check outputs and counter mid-cycle, then advance one clock; the bench
  // model counter steps whenever a bubble is expected.
  task automatic cycle(input string name, input logic [4:0] exp);
    @(negedge clk);
    check_out(name, exp);
    check_cnt(name, exp_cnt);
    if (exp == STALL) exp_cnt = exp_cnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 4'd0;
  endtask

  vec_t idle_v, lu_v, lubr_v;

  initial begin
    idle_v = mk("idle",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUN);
    lu_v   = mk("lu",     5, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, STALL);
    lubr_v = mk("lubr",   5, 0, 1, 1, 1, 1, 5, 1, 1, 0, 0, 0, 0, STALL);

    vecs[0]  = mk("no_hazard",      1, 2, 1, 1, 0, 0, 3, 1, 1, 4, 1, 0, 0, RUN);
    vecs[1]  = mk("load_use_rs1",   5, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, STALL);
    vecs[2]  = mk("load_use_rs2",   3, 5, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, STALL);
    vecs[3]  = mk("load_no_use",    5, 1, 0, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, RUN);
    vecs[4]  = mk("load_x0",        0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, RUN);
    vecs[5]  = mk("alu_jalr",       7, 0, 1, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0, STALL);
    vecs[6]  = mk("alu_fwd_ok",     7, 0, 1, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0, RUN);
    vecs[7]  = mk("alu_nowrite_br", 7, 0, 1, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, RUN);
    vecs[8]  = mk("alu_jalr_x0",    0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, RUN);
    vecs[9]  = mk("mem_load_br",    1, 9, 1, 1, 1, 0, 2, 0, 1, 9, 1, 0, 0, STALL);
    vecs[10] = mk("mem_load_nobr",  1, 9, 1, 1, 0, 0, 2, 0, 1, 9, 1, 0, 0, RUN);
    vecs[11] = mk("taken_flush",    1, 2, 1, 1, 1, 1, 3, 0, 1, 4, 1, 0, 0, FLUSH);
    vecs[12] = mk("taken_stalled",  7, 0, 1, 0, 1, 1, 7, 0, 1, 0, 0, 0, 0, STALL);
    vecs[13] = mk("icache_freeze",  5, 1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 1, 0, FRZ);
    vecs[14] = mk("dcache_taken",   1, 2, 1, 1, 1, 1, 3, 0, 1, 4, 1, 0, 1, FRZ);

    // Reset overrides a visible hazard and a taken branch.
    apply(lubr_v);
    rst = 1'b1;
    exp_cnt = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_out("reset_outputs", RUN);
    check_cnt("reset_count", 4'd0);
    apply(idle_v);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-cycle table, every vector starts and ends in IDLE.
    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      cycle(vecs[i].name, vecs[i].exp);
    end
    apply(idle_v);
    cycle("after_table", RUN);

    // Load-use: one bubble, then the load sits in MEM and no branch -> run.
    do_reset();
    apply(lu_v);
    cycle("lu_bubble", STALL);
    apply(mk("lu_next", 6, 1, 1, 1, 0, 0, 0, 0, 0, 5, 1, 0, 0, RUN));
    cycle("lu_next", RUN);
    check_cnt("lu_count", 4'd1);

    // Load feeding a branch: two bubbles ignoring branch_taken, then flush.
    do_reset();
    apply(lubr_v);
    cycle("lubr_b1", STALL);
    apply(mk("lubr_b2", 5, 0, 1, 1, 1, 1, 0, 0, 0, 5, 1, 0, 0, STALL));
    cycle("lubr_b2", STALL);
    apply(mk("lubr_go", 5, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, FLUSH));
    cycle("lubr_flush", FLUSH);
    check_cnt("lubr_count", 4'd2);

    // Freeze between the two bubbles: HOLD resumes after release.
    do_reset();
    apply(lubr_v);
    cycle("frz_b1", STALL);
    apply(mk("frz_on", 5, 0, 1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 1, FRZ));
    for (int i = 0; i < 3; i++) cycle("frz_hold", FRZ);
    apply(mk("frz_rel", 5, 0, 1, 1, 1, 0, 0, 0, 0, 5, 1, 0, 0, STALL));
    cycle("frz_b2", STALL);
    apply(idle_v);
    cycle("frz_done", RUN);
    check_cnt("frz_count", 4'd2);

    // Reset asserted while in HOLD discards the pending bubble.
    do_reset();
    apply(lubr_v);
    cycle("rh_b1", STALL);
    rst = 1'b1;
    apply(idle_v);
    @(negedge clk);
    check_out("rh_in_reset", RUN);
    check_cnt("rh_cleared", 4'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_cnt = 4'd0;
    cycle("rh_idle", RUN);
    check_cnt("rh_count", 4'd0);

    // Counter wraps from 15 to 0.
    do_reset();
    apply(lu_v);
    for (int i = 0; i < 16; i++) cycle("wrap_bubble", STALL);
    apply(idle_v);
    @(negedge clk);
    check_cnt("wrap_zero", 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
